// File: rtl/caf_pkg.sv
// Shared types and helpers for the CAF arg_max scheduler.
package caf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_RES,
        DONE
    } caf_state_t;

    localparam int CAF_I_BITS   = 16;
    localparam int CAF_Q_BITS   = 16;
    localparam int CAF_MAX_BITS = 32;

    // Ceiling log2 for elaboration-time width derivation; caf_clog2(1) = 0.
    function automatic int caf_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/caf_best_tracker.sv
// Running-best register for per-bin arg_max results: strict-greater compare, first result always loads.
module caf_best_tracker
    import caf_pkg::*;
#(
    parameter int MAX_BITS = CAF_MAX_BITS,
    parameter int IDX_BITS = 6,
    parameter int BIN_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic                first,
    input  logic [MAX_BITS-1:0] cand_max,
    input  logic [IDX_BITS-1:0] cand_index,
    input  logic [BIN_BITS-1:0] cand_bin,
    output logic [MAX_BITS-1:0] best_max,
    output logic [IDX_BITS-1:0] best_index,
    output logic [BIN_BITS-1:0] best_bin,
    output logic [MAX_BITS-1:0] nxt_max,
    output logic [IDX_BITS-1:0] nxt_index,
    output logic [BIN_BITS-1:0] nxt_bin
);

    logic take;

    // Ties keep the earlier bin, so only a strictly larger maximum replaces the best.
    assign take = load && (first || (cand_max > best_max));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        nxt_max   = best_max;
        nxt_index = best_index;
        nxt_bin   = best_bin;
        if (take) begin
            nxt_max   = cand_max;
            nxt_index = cand_index;
            nxt_bin   = cand_bin;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            best_max   <= '0;
            best_index <= '0;
            best_bin   <= '0;
        end else if (clear) begin
            best_max   <= '0;
            best_index <= '0;
            best_bin   <= '0;
        end else begin
            best_max   <= nxt_max;
            best_index <= nxt_index;
            best_bin   <= nxt_bin;
        end
    end

endmodule

// File: rtl/caf_argmax_sched.sv
// Sequences one shared arg_max engine across CAF frequency bins and reports the global (bin, index, max) peak.
module caf_argmax_sched
    import caf_pkg::*;
#(
    parameter int I_BITS   = CAF_I_BITS,
    parameter int Q_BITS   = CAF_Q_BITS,
    parameter int MAX_BITS = CAF_MAX_BITS,
    parameter int BIN_LEN  = 64,
    parameter int NUM_BINS = 8,
    parameter int IDX_BITS = caf_clog2(BIN_LEN),
    parameter int BIN_BITS = (NUM_BINS > 2) ? caf_clog2(NUM_BINS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [I_BITS-1:0]   in_xi,
    input  logic [Q_BITS-1:0]   in_xq,
    output logic                am_valid,
    input  logic                am_ready,
    output logic [I_BITS-1:0]   am_xi,
    output logic [Q_BITS-1:0]   am_xq,
    output logic                am_last,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [MAX_BITS-1:0] res_max,
    input  logic [IDX_BITS-1:0] res_index,
    output logic                done,
    output logic [MAX_BITS-1:0] peak_max,
    output logic [IDX_BITS-1:0] peak_index,
    output logic [BIN_BITS-1:0] peak_bin
);

    caf_state_t          state, state_nxt;
    logic [IDX_BITS-1:0] samp_cnt;
    logic [BIN_BITS-1:0] bin_cnt;
    logic                samp_last, bin_last;
    logic                start_acc, am_xfer, res_xfer;
    logic [MAX_BITS-1:0] best_max, nxt_max;
    logic [IDX_BITS-1:0] best_index, nxt_index;
    logic [BIN_BITS-1:0] best_bin, nxt_bin;

    assign samp_last = (samp_cnt == IDX_BITS'(BIN_LEN - 1));
    assign bin_last  = (bin_cnt == BIN_BITS'(NUM_BINS - 1));
    assign start_acc = (state == IDLE) && start;
    assign am_xfer   = am_valid && am_ready;
    assign res_xfer  = res_valid && res_ready;

    // Samples pass straight through; only the handshake is gated by state.
    assign am_xi = in_xi;
    assign am_xq = in_xq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        am_valid  = 1'b0;
        am_last   = 1'b0;
        res_ready = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                am_valid = in_valid;
                in_ready = am_ready;
                am_last  = in_valid && samp_last;
                if (in_valid && am_ready && samp_last) state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                res_ready = 1'b1;
                if (res_valid) state_nxt = bin_last ? DONE : STREAM;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_cnt <= '0;
            bin_cnt  <= '0;
            busy     <= 1'b0;
        end else begin
            if (start_acc) begin
                samp_cnt <= '0;
                bin_cnt  <= '0;
                busy     <= 1'b1;
            end
            if (am_xfer) samp_cnt <= samp_last ? '0 : samp_cnt + 1'b1;
            if (res_xfer) begin
                if (bin_last) busy <= 1'b0;
                else          bin_cnt <= bin_cnt + 1'b1;
            end
        end
    end

    // The peak is taken from the tracker's next value so it is valid during the done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_max   <= '0;
            peak_index <= '0;
            peak_bin   <= '0;
        end else if (res_xfer && bin_last) begin
            peak_max   <= nxt_max;
            peak_index <= nxt_index;
            peak_bin   <= nxt_bin;
        end
    end

    caf_best_tracker #(
        .MAX_BITS (MAX_BITS),
        .IDX_BITS (IDX_BITS),
        .BIN_BITS (BIN_BITS)
    ) u_best (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_acc),
        .load       (res_xfer),
        .first      (bin_cnt == '0),
        .cand_max   (res_max),
        .cand_index (res_index),
        .cand_bin   (bin_cnt),
        .best_max   (best_max),
        .best_index (best_index),
        .best_bin   (best_bin),
        .nxt_max    (nxt_max),
        .nxt_index  (nxt_index),
        .nxt_bin    (nxt_bin)
    );

endmodule

// File: tb/tb_caf_argmax_sched.sv
// Scoreboard bench for caf_argmax_sched: bench plays both correlator and arg_max engine.
module tb_caf_argmax_sched;

    localparam int BL = 4;
    localparam int NB = 3;

    typedef struct {
        logic [31:0] mx;
        logic [1:0]  idx;
        logic [1:0]  bin;
    } peak_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, in_valid = 1'b0, am_ready = 1'b0, res_valid = 1'b0;
    logic [15:0] in_xi = '0, in_xq = '0;
    logic [31:0] res_max = '0;
    logic [1:0]  res_index = '0;
    logic        busy, in_ready, am_valid, am_last, res_ready, done;
    logic [15:0] am_xi, am_xq;
    logic [31:0] peak_max;
    logic [1:0]  peak_index, peak_bin;

    logic        start1 = 1'b0, in_valid1 = 1'b0, am_ready1 = 1'b0, res_valid1 = 1'b0;
    logic [15:0] in_xi1 = '0, in_xq1 = '0;
    logic [31:0] res_max1 = '0;
    logic [1:0]  res_index1 = '0;
    logic        busy1, in_ready1, am_valid1, am_last1, res_ready1, done1;
    logic [15:0] am_xi1, am_xq1;
    logic [31:0] peak_max1;
    logic [1:0]  peak_index1;
    logic [0:0]  peak_bin1;

    int    n_vec = 0;
    int    n_err = 0;
    peak_t exp_q[$];
    peak_t prev = '{32'd0, 2'd0, 2'd0};

    always #5 clk = ~clk;

    caf_argmax_sched #(.BIN_LEN(BL), .NUM_BINS(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_xi(in_xi), .in_xq(in_xq),
        .am_valid(am_valid), .am_ready(am_ready), .am_xi(am_xi), .am_xq(am_xq), .am_last(am_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_max(res_max), .res_index(res_index),
        .done(done), .peak_max(peak_max), .peak_index(peak_index), .peak_bin(peak_bin)
    );

    caf_argmax_sched #(.BIN_LEN(BL), .NUM_BINS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_xi(in_xi1), .in_xq(in_xq1),
        .am_valid(am_valid1), .am_ready(am_ready1), .am_xi(am_xi1), .am_xq(am_xq1), .am_last(am_last1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_max(res_max1), .res_index(res_index1),
        .done(done1), .peak_max(peak_max1), .peak_index(peak_index1), .peak_bin(peak_bin1)
    );

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_vec++;
        if ({busy, done, in_ready, am_valid, am_last, res_ready, peak_max, peak_index, peak_bin} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b in_ready=%b am_valid=%b am_last=%b res_ready=%b peak=%0d/%0d/%0d, want all 0",
                     busy, done, in_ready, am_valid, am_last, res_ready, peak_max, peak_index, peak_bin);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // One sweep on the 3-bin DUT. bp: backpressure/gap patterns; poke: start while busy and on done;
    // abort: asynchronous reset in bin 1 mid-stream.
    task automatic run_sweep(input logic [31:0] m0, m1, m2, input logic [1:0] i0, i1, i2,
                             input bit bp, input bit poke, input bit abort);
        logic [31:0] mx [3];
        logic [1:0]  ix [3];
        peak_t       e, got;
        int          xfer, bin, total, rb;
        bit          pend, fin, done_exp, got_done, aborted;
        mx[0] = m0; mx[1] = m1; mx[2] = m2;
        ix[0] = i0; ix[1] = i1; ix[2] = i2;
        e = '{mx[0], ix[0], 2'd0};
        for (int b = 1; b < NB; b++) begin
            if (mx[b] > e.mx) e = '{mx[b], ix[b], 2'(b)};
        end
        exp_q.push_back(e);
        xfer = 0; bin = 0; total = 0; rb = 0;
        pend = 0; fin = 0; done_exp = 0; got_done = 0; aborted = 0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b want 1", busy); end

        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid = bp ? (cyc % 3 != 2) : 1'b1;
            am_ready = bp ? (cyc % 2 == 0) : 1'b1;
            in_xi    = 16'($urandom);
            in_xq    = 16'($urandom);
            start    = poke && (cyc == 5);
            if (pend) begin
                res_valid = 1'b1; res_max = mx[rb]; res_index = ix[rb];
            end else begin
                res_valid = bp; res_max = 32'hFFFF_FFFF; res_index = 2'd3;
            end
            @(negedge clk);

            n_vec++;
            if (done !== done_exp) begin n_err++; $display("FAIL done_timing: got %b want %b", done, done_exp); end
            if (!done) begin
                n_vec++;
                if (peak_max !== prev.mx || peak_index !== prev.idx || peak_bin !== prev.bin) begin
                    n_err++;
                    $display("FAIL peak_hold: got %0d/%0d/%0d want %0d/%0d/%0d",
                             peak_max, peak_index, peak_bin, prev.mx, prev.idx, prev.bin);
                end
            end

            if (done_exp) begin
                got_done = 1;
                got = exp_q.pop_front();
                n_vec++;
                if (peak_max !== got.mx || peak_index !== got.idx || peak_bin !== got.bin) begin
                    n_err++;
                    $display("FAIL peak_result: got max=%0d idx=%0d bin=%0d want max=%0d idx=%0d bin=%0d",
                             peak_max, peak_index, peak_bin, got.mx, got.idx, got.bin);
                end
                n_vec++;
                if (busy !== 1'b0 || in_ready !== 1'b0 || am_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_cycle: busy=%b in_ready=%b am_valid=%b want 0/0/0", busy, in_ready, am_valid);
                end
                n_vec++;
                if (total !== BL * NB) begin n_err++; $display("FAIL transfer_total: got %0d want %0d", total, BL * NB); end
                prev = got;
                if (poke) start = 1'b1;
                break;
            end else if (pend) begin
                n_vec++;
                if (in_ready !== 1'b0 || am_valid !== 1'b0 || am_last !== 1'b0 || res_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL wait_res: in_ready=%b am_valid=%b am_last=%b res_ready=%b want 0/0/0/1",
                             in_ready, am_valid, am_last, res_ready);
                end
                if (res_valid && res_ready) begin
                    pend = 0;
                    if (bin == NB - 1) begin fin = 1; done_exp = 1; end
                    else bin++;
                end
            end else if (!fin) begin
                n_vec++;
                if (am_valid !== in_valid || in_ready !== am_ready || am_xi !== in_xi || am_xq !== in_xq ||
                    res_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_path: am_valid=%b/%b in_ready=%b/%b xi=%h/%h res_ready=%b busy=%b",
                             am_valid, in_valid, in_ready, am_ready, am_xi, in_xi, res_ready, busy);
                end
                n_vec++;
                if (am_last !== (in_valid && xfer == BL - 1)) begin
                    n_err++;
                    $display("FAIL am_last: got %b want %b (bin %0d sample %0d)", am_last, in_valid && xfer == BL - 1, bin, xfer);
                end
                if (in_valid && am_ready) begin
                    total++;
                    if (xfer == BL - 1) begin xfer = 0; pend = 1; rb = bin; end
                    else xfer++;
                end
                if (abort && bin == 1 && xfer == 2) begin
                    #1 reset = 1'b1;
                    #1;
                    n_vec++;
                    if ({busy, done, in_ready, am_valid, am_last, res_ready, peak_max, peak_index, peak_bin} !== '0) begin
                        n_err++;
                        $display("FAIL async_abort: busy=%b in_ready=%b am_valid=%b am_last=%b peak=%0d/%0d/%0d want all 0",
                                 busy, in_ready, am_valid, am_last, peak_max, peak_index, peak_bin);
                    end
                    reset = 1'b0;
                    void'(exp_q.pop_front());
                    prev = '{32'd0, 2'd0, 2'd0};
                    aborted = 1;
                    break;
                end
            end
            @(posedge clk); #1;
        end

        if (aborted) begin
            @(posedge clk); #1;
        end else if (!got_done) begin
            n_vec++; n_err++;
            $display("FAIL sweep_timeout: got no done within budget, want one done");
        end else begin
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                n_vec++;
                if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL post_done_idle: done=%b busy=%b in_ready=%b want 0/0/0", done, busy, in_ready);
                end
            end
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_basic();
        run_sweep(32'd5, 32'd9, 32'd7, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_tie();
        run_sweep(32'd8, 32'd8, 32'd3, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_sweep(32'd2, 32'd6, 32'd6, 2'd0, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_sweep(32'd1, 32'd2, 32'd3, 2'd2, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);
        run_sweep(32'd11, 32'd4, 32'd10, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_sweep(32'd20, 32'd30, 32'd40, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);
        run_sweep(32'd4, 32'd4, 32'd10, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_bin();
        peak_t e, got;
        int    xfer;
        bit    ok;
        e = '{32'd0, 2'd3, 2'd0};
        exp_q.push_back(e);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        in_valid1 = 1'b1; am_ready1 = 1'b1;
        xfer = 0; ok = 0;
        for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
            @(negedge clk);
            n_vec++;
            if (am_last1 !== (xfer == BL - 1)) begin
                n_err++; $display("FAIL single_am_last: got %b want %b at sample %0d", am_last1, xfer == BL - 1, xfer);
            end
            if (am_valid1 && am_ready1) begin
                if (xfer == BL - 1) ok = 1;
                xfer++;
            end
            @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
        res_valid1 = 1'b1; res_max1 = 32'd0; res_index1 = 2'd3;
        ok = 0;
        for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
            @(negedge clk);
            if (res_valid1 && res_ready1) ok = 1;
            @(posedge clk); #1;
            res_valid1 = 1'b0;
        end
        @(negedge clk);
        got = exp_q.pop_front();
        n_vec++;
        if (done1 !== 1'b1 || peak_max1 !== got.mx || peak_index1 !== got.idx || peak_bin1 !== got.bin[0]) begin
            n_err++;
            $display("FAIL single_bin: done=%b peak=%0d/%0d/%0d want done=1 peak=%0d/%0d/%0d",
                     done1, peak_max1, peak_index1, peak_bin1, got.mx, got.idx, got.bin[0]);
        end
        @(negedge clk);
        n_vec++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            n_err++; $display("FAIL single_done_pulse: done=%b busy=%b want 0/0", done1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_single_bin();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/caf_argmax_sched.md
Name: caf_argmax_sched

Overview:
- Sequences the shared arg_max engine across the frequency-offset bins of a cross-ambiguity function (CAF) search.
- Gates the correlator sample stream into the engine one bin (frame) at a time and marks each frame's last sample.
- Collects each per-bin (max, index) result and keeps a running global best.
- Reports the CAF peak as (bin, index, max) when the sweep completes.
- Sits between the correlator output stream and a single arg_max instance.

Parameters:
- I_BITS, 16, width of signed in-phase sample.
- Q_BITS, 16, width of signed quadrature sample.
- MAX_BITS, 32, width of arg_max magnitude result (unsigned).
- BIN_LEN, 64, samples per frequency bin (>=2).
- NUM_BINS, 8, frequency bins per sweep (>=1).
- IDX_BITS, clog2(BIN_LEN), sample-index width.
- BIN_BITS, max(1, clog2(NUM_BINS)), bin-number width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle sweep request; sampled only in IDLE.
- busy  out  1  high from accepted start until done pulse.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  upstream sample ready.
- in_xi  in  I_BITS  upstream I sample.
- in_xq  in  Q_BITS  upstream Q sample.
- am_valid  out  1  sample valid to arg_max.
- am_ready  in  1  arg_max ready.
- am_xi  out  I_BITS  I sample to arg_max.
- am_xq  out  Q_BITS  Q sample to arg_max.
- am_last  out  1  marks the final sample of a bin.
- res_valid  in  1  arg_max result valid.
- res_ready  out  1  scheduler accepts result.
- res_max  in  MAX_BITS  per-bin maximum.
- res_index  in  IDX_BITS  per-bin argmax index.
- done  out  1  one-cycle sweep-complete pulse.
- peak_max  out  MAX_BITS  global maximum.
- peak_index  out  IDX_BITS  sample index of the global maximum.
- peak_bin  out  BIN_BITS  bin of the global maximum.

Behaviour:
- Reset: asynchronous, clears state to IDLE. All counters, busy, done, in_ready, am_valid, am_last, res_ready and peak_* go to 0.
- Sample transfer occurs when valid & ready are both high on a rising clk.

FSM states:
- IDLE:
  - in_ready = 0, am_valid = 0.
  - start=1 → STREAM; clears bin_cnt, samp_cnt, best registers; busy=1 from the next cycle.
- STREAM:
  - Combinational pass-through: am_valid=in_valid, in_ready=am_ready, am_xi/am_xq=in_xi/in_xq.
  - am_last = (samp_cnt == BIN_LEN-1).
  - samp_cnt increments on each am transfer.
  - Transfer with am_last → samp_cnt=0, go to WAIT_RES; the next cycle has in_ready=0.
- WAIT_RES:
  - in_ready=0, am_valid=0, res_ready=1.
  - On res_valid: if bin_cnt==0 OR res_max > best_max (strict), load best_max/best_index/best_bin=bin_cnt.
  - Ties keep the earlier bin.
  - Then bin_cnt==NUM_BINS-1 → DONE; otherwise bin_cnt++ → STREAM.
- DONE:
  - One cycle: done=1; peak_* registered from best_*; busy=0 on the same edge; → IDLE.

Further rules:
- peak_* hold until the next sweep's DONE; they are not cleared on start.
- start while busy is ignored; start on the DONE cycle is ignored.
- A res_valid arriving outside WAIT_RES is not accepted (res_ready=0).
- Upstream stall mid-bin: samp_cnt holds, with no timeout.
- Reset mid-sweep aborts immediately; no done is issued, and peak_* clear to 0.
- Counters never wrap: samp_cnt is bounded by BIN_LEN-1 and bin_cnt by NUM_BINS-1.
- Latency:
  - Data path has 0 cycles (combinational).
  - Result capture takes 1 cycle after the res handshake.
  - done asserts 1 cycle after the final result accept.

Decomposition:
- Shared package caf_pkg:
  - State enum (IDLE, STREAM, WAIT_RES, DONE).
  - Default width constants I_BITS/Q_BITS/MAX_BITS.
  - clog2 helper.
- One natural sub-module, caf_best_tracker: the compare/load register for best_max/best_index/best_bin, with load, first and clear inputs.
- The FSM and counters stay in the top.

Test Plan:
- BIN_LEN=4, NUM_BINS=3, continuous valid, model returns maxima 5, 9, 7 at indices 1, 2, 0 → am_last on the 4th, 8th and 12th transfers; done one pulse; peak_max=9, peak_index=2, peak_bin=1.
- Tie: maxima 8, 8, 3 → peak_bin=0 (strict greater); index is taken from bin 0.
- Backpressure: am_ready toggles 1,0,1,0; in_valid gaps every 3rd cycle → exactly BIN_LEN transfers per bin; am_last never asserts on a stalled cycle; in_ready=0 throughout WAIT_RES.
- start pulsed while busy and on the DONE cycle → ignored; exactly one done per accepted start; peak_* unchanged until the second sweep completes.
- reset asserted mid-STREAM of bin 1 (asynchronous, between edges) → outputs 0 immediately; FSM in IDLE; a new sweep runs cleanly from bin 0.
- NUM_BINS=1, single result max=0 → loads via the first-bin rule; peak_max=0, peak_bin=0; done asserts.
